// File: rtl/cyc_bpuf_array_ctrl.sv
// Evaluation controller for an array of bistable PUF cells.
// Drives masked excite pulses, waits out a settle window and samples the
// cells, then repeats this VOTES times. Each response bit is the majority of
// its votes, and a per-bit flag marks bits whose votes were not unanimous.
module cyc_bpuf_array_ctrl #(
    parameter int unsigned NUM_BITS      = 8,
    parameter int unsigned EXCITE_CYCLES = 4,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned VOTES         = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [NUM_BITS-1:0] challenge,
    output logic [NUM_BITS-1:0] excite_o,
    input  logic [NUM_BITS-1:0] cell_q_i,
    output logic                busy,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [NUM_BITS-1:0] response,
    output logic [NUM_BITS-1:0] unstable
);

    localparam int unsigned MAX_PH = (EXCITE_CYCLES > SETTLE_CYCLES) ? EXCITE_CYCLES : SETTLE_CYCLES;
    localparam int unsigned PW     = $clog2(MAX_PH + 1);
    localparam int unsigned CW     = $clog2(VOTES + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXCITE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_e;

    state_e                      state_q, state_d;
    logic [NUM_BITS-1:0]         chal_q, chal_d;
    logic [PW-1:0]               phase_q, phase_d;
    logic [CW-1:0]               vidx_q, vidx_d;
    logic [NUM_BITS-1:0][CW-1:0] cnt_q, cnt_d;
    logic [NUM_BITS-1:0]         excite_q, excite_d;
    logic                        busy_q, busy_d;
    logic                        resp_valid_q, resp_valid_d;
    logic [NUM_BITS-1:0]         response_q, response_d;
    logic [NUM_BITS-1:0]         unstable_q, unstable_d;

    assign excite_o   = excite_q;
    assign busy       = busy_q;
    assign resp_valid = resp_valid_q;
    assign response   = response_q;
    assign unstable   = unstable_q;

    // Next-state, vote accumulation and response/handshake logic.
    always_comb begin
        state_d      = state_q;
        chal_d       = chal_q;
        phase_d      = phase_q;
        vidx_d       = vidx_q;
        cnt_d        = cnt_q;
        excite_d     = '0;
        busy_d       = busy_q;
        resp_valid_d = resp_valid_q;
        response_d   = response_q;
        unstable_d   = unstable_q;

        if (resp_valid_q && resp_ready) begin
            resp_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start && !resp_valid_q) begin
                    chal_d  = challenge;
                    phase_d = '0;
                    vidx_d  = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_EXCITE;
                end
            end
            ST_EXCITE: begin
                // excite_o is registered, so it trails the state by one cycle
                excite_d = chal_q;
                if (phase_q == PW'(EXCITE_CYCLES - 1)) begin
                    phase_d = '0;
                    state_d = ST_SETTLE;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            ST_SETTLE: begin
                if (phase_q == PW'(SETTLE_CYCLES - 1)) begin
                    phase_d = '0;
                    state_d = ST_SAMPLE;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            ST_SAMPLE: begin
                for (int unsigned i = 0; i < NUM_BITS; i++) begin
                    cnt_d[i] = cnt_q[i] + CW'(cell_q_i[i] & chal_q[i]);
                end
                if (vidx_q == CW'(VOTES - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    vidx_d  = vidx_q + 1'b1;
                    state_d = ST_EXCITE;
                end
            end
            ST_DONE: begin
                for (int unsigned i = 0; i < NUM_BITS; i++) begin
                    response_d[i] = chal_q[i] & (cnt_q[i] > CW'(VOTES / 2));
                    unstable_d[i] = chal_q[i] & (cnt_q[i] != '0) & (cnt_q[i] != CW'(VOTES));
                end
                resp_valid_d = 1'b1;
                busy_d       = 1'b0;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears excite_o without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            chal_q       <= '0;
            phase_q      <= '0;
            vidx_q       <= '0;
            cnt_q        <= '0;
            excite_q     <= '0;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            response_q   <= '0;
            unstable_q   <= '0;
        end else begin
            state_q      <= state_d;
            chal_q       <= chal_d;
            phase_q      <= phase_d;
            vidx_q       <= vidx_d;
            cnt_q        <= cnt_d;
            excite_q     <= excite_d;
            busy_q       <= busy_d;
            resp_valid_q <= resp_valid_d;
            response_q   <= response_d;
            unstable_q   <= unstable_d;
        end
    end

endmodule

// File: tb/tb_cyc_bpuf_array_ctrl.sv
// Self-checking bench for cyc_bpuf_array_ctrl with a response scoreboard.
module tb_cyc_bpuf_array_ctrl;

    localparam int unsigned NB  = 4;
    localparam int unsigned LAT = 19;

    typedef struct packed {
        logic [NB-1:0] resp;
        logic [NB-1:0] unst;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [NB-1:0] challenge;
    logic [NB-1:0] excite_o;
    logic [NB-1:0] cell_q_i;
    logic          busy;
    logic          resp_valid;
    logic          resp_ready;
    logic [NB-1:0] response;
    logic [NB-1:0] unstable;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    cyc_bpuf_array_ctrl #(
        .NUM_BITS     (NB),
        .EXCITE_CYCLES(2),
        .SETTLE_CYCLES(3),
        .VOTES        (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .challenge (challenge),
        .excite_o  (excite_o),
        .cell_q_i  (cell_q_i),
        .busy      (busy),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .response  (response),
        .unstable  (unstable)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected majority/instability from the three per-vote cell patterns.
    function automatic exp_t model(input logic [NB-1:0] chal, input logic [NB-1:0] p0,
                                   input logic [NB-1:0] p1, input logic [NB-1:0] p2);
        exp_t e;
        int   n;
        e = '0;
        for (int i = 0; i < NB; i++) begin
            n = int'(p0[i]) + int'(p1[i]) + int'(p2[i]);
            e.resp[i] = chal[i] && (n >= 2);
            e.unst[i] = chal[i] && (n != 0) && (n != 3);
        end
        return e;
    endfunction

    // One full evaluation; cycle c counts edges after the accepting edge.
    task automatic run_eval(input logic [NB-1:0] chal, input logic [NB-1:0] p0,
                            input logic [NB-1:0] p1, input logic [NB-1:0] p2);
        logic [NB-1:0] pats [3];
        logic [NB-1:0] exc_exp;
        exp_t          e;
        pats[0] = p0;
        pats[1] = p1;
        pats[2] = p2;
        exp_q.push_back(model(chal, p0, p1, p2));
        @(posedge clk); #1;
        start     = 1'b1;
        challenge = chal;
        cell_q_i  = p0;
        @(posedge clk); #1;
        start     = 1'b0;
        challenge = ~chal;
        @(negedge clk);
        chk("accept_busy", 32'(busy), 32'd1);
        chk("accept_excite", 32'(excite_o), 32'd0);
        for (int c = 1; c <= int'(LAT); c++) begin
            @(posedge clk); #1;
            cell_q_i = pats[(c / 6 > 2) ? 2 : c / 6];
            @(negedge clk);
            if (c < int'(LAT)) begin
                exc_exp = (((c - 1) % 6) < 2) ? chal : '0;
                chk("excite", 32'(excite_o), 32'(exc_exp));
                chk("busy", 32'(busy), 32'd1);
                chk("rv_early", 32'(resp_valid), 32'd0);
            end else begin
                chk("rv_latency", 32'(resp_valid), 32'd1);
                chk("busy_done", 32'(busy), 32'd0);
                chk("excite_done", 32'(excite_o), 32'd0);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("response", 32'(response), 32'(e.resp));
                    chk("unstable", 32'(unstable), 32'(e.unst));
                end else begin
                    chk("sb_empty", 32'd1, 32'(exp_q.size()));
                end
            end
        end
    endtask

    // Hold off the consumer while pulsing start, then retire the response.
    task automatic consume(input int hold);
        logic [NB-1:0] r0;
        logic [NB-1:0] u0;
        r0 = response;
        u0 = unstable;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            start = (i % 2) == 0;
            @(negedge clk);
            chk("hold_rv", 32'(resp_valid), 32'd1);
            chk("hold_busy", 32'(busy), 32'd0);
            chk("hold_resp", 32'(response), 32'(r0));
            chk("hold_unst", 32'(unstable), 32'(u0));
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        start      = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        start      = 1'b0;
        @(negedge clk);
        chk("ready_rv_clr", 32'(resp_valid), 32'd0);
        chk("ready_no_start", 32'(busy), 32'd0);
        chk("ready_keep_resp", 32'(response), 32'(r0));
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b1;
        challenge  = '1;
        cell_q_i   = '1;
        resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_excite", 32'(excite_o), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rv", 32'(resp_valid), 32'd0);
        chk("rst_resp", 32'(response), 32'd0);
        chk("rst_unst", 32'(unstable), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        #2 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_excite", 32'(excite_o), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
        end

        run_eval(4'b1111, 4'b1010, 4'b1010, 4'b1010);
        consume(10);
        run_eval(4'b1111, 4'b0001, 4'b0011, 4'b0111);
        consume(1);
        run_eval(4'b0101, 4'b1111, 4'b1111, 4'b1111);
        consume(0);
        run_eval(4'b0000, 4'b1111, 4'b0101, 4'b1111);
        consume(0);

        // Abort during the second excite phase with all cells reading 1.
        @(posedge clk); #1;
        start     = 1'b1;
        challenge = 4'b1111;
        cell_q_i  = 4'b1111;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("abort_pre_excite", 32'(excite_o), 32'hf);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_excite_async", 32'(excite_o), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rv", 32'(resp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_eval(4'b1111, 4'b0000, 4'b0000, 4'b1000);
        consume(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
